imm_decode_stage: RTL and testbench

- Registered, parametrised immediate-generation stage for the RV32I multi-cycle core, and the successor to the combinational immediate generator.
- Accepts fetched instructions over a valid/ready handshake and classifies the instruction format.
- Produces the XLEN-wide sign- or zero-extended immediate, the format tag and shift-immediate flags.
- Buffers results in a 2-entry skid buffer, so decode sustains one instruction/cycle under back-pressure and can be flushed on redirect.

---
 rtl/imm_decode_pkg.sv | 57 +++++
 rtl/imm_decode_stage_if.sv | 40 ++++
 rtl/imm_extract.sv | 92 +++++++++
 rtl/imm_decode_stage.sv | 132 +++++++++++++
 tb/tb_imm_decode_stage.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_decode_pkg.sv
// -----------------------------------------------------------------------------
// imm_decode_pkg
// Shared types and constants for the registered immediate-decode stage.
//   imm_fmt_e    : immediate format tag carried with every decoded entry
//   OP_*         : RV32I major opcodes that carry (or explicitly lack) an imm
//   F3_*         : func3 codes that turn OP_IMM into a shift-immediate
//   buf_state_e  : occupancy of the 2-entry output buffer (also a debug port)
//   imm_meta_t   : the non-immediate fields of a decoded entry
//   shamt_width(): shift-amount width derived from XLEN
// The decoded entry itself is {imm[XLEN-1:0], imm_meta_t}. The imm field is
// XLEN wide, so each module builds the full entry type locally from its own
// XLEN parameter.
// Optional feature macro: IMM_DECODE_ILLEGAL_EN (see imm_extract).
// -----------------------------------------------------------------------------
package imm_decode_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6,
    FMT_NONE = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  typedef struct packed {
    imm_fmt_e fmt;
    logic     shift_arith;
    logic     illegal;
  } imm_meta_t;

  function automatic int shamt_width(input int xlen);
    return (xlen == 64) ? 6 : 5;
  endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// -----------------------------------------------------------------------------
// imm_decode_stage_if
// Bundles the fetch-side and consumer-side handshakes of imm_decode_stage.
//   in_valid/in_ready/in_instr                 : instruction input channel
//   out_valid/out_ready/out_imm/out_fmt/
//   out_shift_arith/out_illegal                : decoded result channel
// Modports: master = fetch/consumer side, slave = the decode stage.
//
// Handshake: on each channel a transfer happens at a rising clk edge where
// valid and ready are both 1. A source holding valid=1 may not assume the
// transfer until it sees ready=1 at that edge; ready never depends
// combinationally on valid of the same channel, and in_ready never depends
// on out_ready. While out_valid=1 and out_ready=0 all out_* fields are held.
// -----------------------------------------------------------------------------
interface imm_decode_stage_if #(
  parameter int XLEN = 32
);
  import imm_decode_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  imm_fmt_e        out_fmt;
  logic            out_shift_arith;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_shift_arith, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_shift_arith, out_illegal
  );

endinterface

// File: rtl/imm_extract.sv
// -----------------------------------------------------------------------------
// imm_extract
// Purely combinational RV32I instruction -> immediate decoder.
//   instr : raw 32-bit instruction word
//   imm   : XLEN-wide immediate (sign-extended, or zero-extended shamt)
//   meta  : format tag, srai flag and immediate-level illegal flag
// Optional feature macro IMM_DECODE_ILLEGAL_EN: when defined, meta.illegal
// flags unknown opcodes and malformed shift-immediate encodings; otherwise
// it is constant 0 and no check logic exists.
// -----------------------------------------------------------------------------
module imm_extract
  import imm_decode_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_meta_t       meta
);

  logic [6:0] opcode;
  logic [2:0] func3;
  logic       is_shift;

  assign opcode   = instr[6:0];
  assign func3    = instr[14:12];
  assign is_shift = (func3 == F3_SLL) || (func3 == F3_SRX);

  always_comb begin
    imm              = '0;
    meta.fmt         = FMT_NONE;
    meta.shift_arith = 1'b0;
    meta.illegal     = 1'b0;

    // Sizing casts of $signed() operands sign-extend up to XLEN.
    case (opcode)
      OP_LOAD, OP_JALR: begin
        meta.fmt = FMT_I;
        imm      = XLEN'($signed(instr[31:20]));
      end
      OP_IMM: begin
        if (is_shift) begin
          meta.fmt         = FMT_SH;
          imm              = XLEN'(instr[20 +: SHAMT_W]);
          meta.shift_arith = (func3 == F3_SRX) && instr[30];
        end else begin
          meta.fmt = FMT_I;
          imm      = XLEN'($signed(instr[31:20]));
        end
      end
      OP_STORE: begin
        meta.fmt = FMT_S;
        imm      = XLEN'($signed({instr[31:25], instr[11:7]}));
      end
      OP_BRANCH: begin
        meta.fmt = FMT_B;
        imm      = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                  instr[11:8], 1'b0}));
      end
      OP_LUI, OP_AUIPC: begin
        meta.fmt = FMT_U;
        imm      = XLEN'($signed({instr[31:12], 12'b0}));
      end
      OP_JAL: begin
        meta.fmt = FMT_J;
        imm      = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                  instr[30:21], 1'b0}));
      end
      OP_REG: begin
        meta.fmt = FMT_R;
      end
      default: begin
        meta.fmt = FMT_NONE;
      end
    endcase

`ifdef IMM_DECODE_ILLEGAL_EN
    if (meta.fmt == FMT_NONE) begin
      meta.illegal = 1'b1;
    end else if (meta.fmt == FMT_SH) begin
      // RV32 has only a 5-bit shamt, so instr[25] must be clear.
      if ((XLEN == 32) && instr[25]) meta.illegal = 1'b1;
      if ((func3 == F3_SLL) && (instr[31:26] != 6'b000000)) meta.illegal = 1'b1;
      // srli uses 000000, srai uses 010000 in the upper funct bits.
      if ((func3 == F3_SRX) && (instr[31:26] != 6'b000000) &&
          (instr[31:26] != 6'b010000)) meta.illegal = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/imm_decode_stage.sv
// -----------------------------------------------------------------------------
// imm_decode_stage
// Registered immediate-generation stage with a 2-entry skid buffer.
//   clk       : core clock, rising edge
//   rst_n     : asynchronous active-low reset
//   flush     : synchronous discard of all buffered entries (redirect)
//   bus       : imm_decode_stage_if.slave (instruction in, decoded entry out)
//   dbg_state : buffer occupancy state (EMPTY / ONE / TWO)
// Parameter XLEN: 32 or 64. SHAMT_W is derived internally from XLEN.
// Optional feature macro IMM_DECODE_ILLEGAL_EN enables out_illegal
// (decoded in imm_extract; the flag travels with its entry).
//
// The head register drives the outputs; the skid register only fills when
// the head is occupied and not being consumed. in_ready is a flop so the
// fetch side sees no combinational path from out_ready.
// -----------------------------------------------------------------------------
module imm_decode_stage
  import imm_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  imm_decode_stage_if.slave   bus,
  output buf_state_e          dbg_state
);

  localparam int SHAMT_W = shamt_width(XLEN);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
    logic            shift_arith;
    logic            illegal;
  } entry_t;

  localparam entry_t ENTRY_RST = '{imm: '0, fmt: FMT_NONE,
                                   shift_arith: 1'b0, illegal: 1'b0};

  logic [XLEN-1:0] dec_imm;
  imm_meta_t       dec_meta;
  entry_t          dec_entry;

  buf_state_e state_q, state_d;
  entry_t     head_q, head_d;
  entry_t     skid_q, skid_d;
  logic       in_ready_q, in_ready_d;
  logic       push, pop;

  imm_extract #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_extract (
    .instr (bus.in_instr),
    .imm   (dec_imm),
    .meta  (dec_meta)
  );

  assign dec_entry = '{imm: dec_imm, fmt: dec_meta.fmt,
                       shift_arith: dec_meta.shift_arith,
                       illegal: dec_meta.illegal};

  assign push = bus.in_valid && in_ready_q;
  assign pop  = (state_q != ST_EMPTY) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;

    if (flush) begin
      // Entries are dropped by occupancy alone; the data flops keep their
      // stale contents, which are invisible while out_valid=0.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            head_d  = dec_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_d = dec_entry;
          end else if (push) begin
            skid_d  = dec_entry;
            state_d = ST_TWO;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready_q is 0 here, so push cannot occur.
          if (pop) begin
            head_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end

    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      head_q     <= ENTRY_RST;
      skid_q     <= ENTRY_RST;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready        = in_ready_q;
  assign bus.out_valid       = (state_q != ST_EMPTY);
  assign bus.out_imm         = head_q.imm;
  assign bus.out_fmt         = head_q.fmt;
  assign bus.out_shift_arith = head_q.shift_arith;
  assign bus.out_illegal     = head_q.illegal;
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_imm_decode_stage
// Directed cases for imm_decode_stage followed by randomized traffic, all
// checked against an arithmetic reference decoder and an expected queue.
// -----------------------------------------------------------------------------
module tb_imm_decode_stage;
  import imm_decode_pkg::*;

  localparam int XLEN = 32;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic flush;
  buf_state_e dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  imm_decode_stage_if #(.XLEN(XLEN)) bus ();

  imm_decode_stage #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint sx(input longint v, input int n);
    if (v >= (longint'(1) << (n - 1))) return v - (longint'(1) << n);
    return v;
  endfunction

  // Returns {imm[31:0], fmt[2:0], shift_arith, illegal}
  function automatic logic [36:0] ref_decode(input logic [31:0] ins);
    longint   u;
    longint   v;
    imm_fmt_e f;
    logic     sa;
    logic     il;
    logic [6:0] op;
    logic [2:0] f3;
    logic [5:0] top6;
    u    = longint'({32'd0, ins});
    v    = 0;
    f    = FMT_NONE;
    sa   = 1'b0;
    il   = 1'b0;
    op   = ins[6:0];
    f3   = ins[14:12];
    top6 = ins[31:26];
    case (op)
      7'b0000011, 7'b1100111: begin f = FMT_I; v = sx(u >> 20, 12); end
      7'b0010011: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          f  = FMT_SH;
          v  = (u >> 20) % 32;
          sa = (f3 == 3'd5) && ins[30];
        end else begin
          f = FMT_I;
          v = sx(u >> 20, 12);
        end
      end
      7'b0100011: begin
        f = FMT_S;
        v = sx(((u >> 25) * 32) + ((u >> 7) % 32), 12);
      end
      7'b1100011: begin
        f = FMT_B;
        v = sx(((u >> 31) * 4096) + (((u >> 7) % 2) * 2048) +
               (((u >> 25) % 64) * 32) + (((u >> 8) % 16) * 2), 13);
      end
      7'b0110111, 7'b0010111: begin f = FMT_U; v = (u >> 12) * 4096; end
      7'b1101111: begin
        f = FMT_J;
        v = sx(((u >> 31) * 1048576) + (((u >> 12) % 256) * 4096) +
               (((u >> 20) % 2) * 2048) + (((u >> 21) % 1024) * 2), 21);
      end
      7'b0110011: begin f = FMT_R; v = 0; end
      default: begin f = FMT_NONE; v = 0; end
    endcase
`ifdef IMM_DECODE_ILLEGAL_EN
    if (f == FMT_NONE) il = 1'b1;
    if (f == FMT_SH) begin
      if (ins[25]) il = 1'b1;
      if (f3 == 3'd1 && top6 != 6'd0) il = 1'b1;
      if (f3 == 3'd5 && top6 != 6'd0 && top6 != 6'd16) il = 1'b1;
    end
`endif
    return {v[31:0], f, sa, il};
  endfunction

  // ---------------- scoreboard ----------------
  logic [36:0] exp_q[$];

  always @(negedge clk) begin
    logic [36:0] got;
    logic [36:0] e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      chk("out_valid_model", 64'(bus.out_valid), 64'(exp_q.size() != 0));
      chk("in_ready_model", 64'(bus.in_ready), 64'(exp_q.size() < 2));
      if (flush) begin
        exp_q.delete();
      end else begin
        if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
          got = {bus.out_imm, bus.out_fmt, bus.out_shift_arith, bus.out_illegal};
          e   = exp_q.pop_front();
          chk("out_entry", 64'(got), 64'(e));
        end
        if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_decode(bus.in_instr));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_wait(input logic [31:0] instr, input string tag);
    logic ok;
    ok           = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk(tag, 64'(ok), 64'd1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom;
    case ($urandom_range(0, 10))
      0: op = OP_LUI;
      1: op = OP_AUIPC;
      2: op = OP_JAL;
      3: op = OP_JALR;
      4: op = OP_BRANCH;
      5: op = OP_LOAD;
      6: op = OP_STORE;
      7, 8: op = OP_IMM;
      9: op = OP_REG;
      default: op = r[6:0];
    endcase
    if (op == OP_IMM && $urandom_range(0, 1) == 1) begin
      r[14:12] = ($urandom_range(0, 1) == 1) ? 3'b101 : 3'b001;
      case ($urandom_range(0, 2))
        0: r[31:26] = 6'b000000;
        1: r[31:26] = 6'b010000;
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) r[25] = 1'b0;
    end
    return {r[31:7], op};
  endfunction

  logic [31:0] s_instr [4] = '{32'h123450B7, 32'hFE20AC23, 32'hFE000EE3, 32'h001000EF};
  logic [31:0] s_imm   [4] = '{32'h12345000, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000800};
  imm_fmt_e    s_fmt   [4] = '{FMT_U, FMT_S, FMT_B, FMT_J};

  // ---------------- stimulus ----------------
  initial begin
    rst_n         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'd0;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_imm", 64'(bus.out_imm), 64'd0);
    chk("rst_out_fmt", 64'(bus.out_fmt), 64'(FMT_NONE));
    chk("rst_shift_arith", 64'(bus.out_shift_arith), 64'd0);
    chk("rst_illegal", 64'(bus.out_illegal), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // addi x1,x0,-1 : one-cycle latency
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'hFFF00093;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("addi_valid", 64'(bus.out_valid), 64'd1);
    chk("addi_imm", 64'(bus.out_imm), 64'hFFFF_FFFF);
    chk("addi_fmt", 64'(bus.out_fmt), 64'(FMT_I));

    // back-to-back stream, one result per cycle
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_instr = s_instr[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i < 3) bus.in_instr = s_instr[i + 1];
      else       bus.in_valid = 1'b0;
      chk("stream_valid", 64'(bus.out_valid), 64'd1);
      chk("stream_imm", 64'(bus.out_imm), 64'(s_imm[i]));
      chk("stream_fmt", 64'(bus.out_fmt), 64'(s_fmt[i]));
    end
    @(posedge clk); #1;

    // shift immediates
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h4030D093;
    @(posedge clk); #1;
    bus.in_instr = 32'h0230D093;
    chk("srai_imm", 64'(bus.out_imm), 64'd3);
    chk("srai_fmt", 64'(bus.out_fmt), 64'(FMT_SH));
    chk("srai_arith", 64'(bus.out_shift_arith), 64'd1);
    chk("srai_illegal", 64'(bus.out_illegal), 64'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("sh25_imm", 64'(bus.out_imm), 64'd3);
    chk("sh25_arith", 64'(bus.out_shift_arith), 64'd0);
`ifdef IMM_DECODE_ILLEGAL_EN
    chk("sh25_illegal", 64'(bus.out_illegal), 64'd1);
`else
    chk("sh25_illegal", 64'(bus.out_illegal), 64'd0);
`endif
    @(posedge clk); #1;

    // back-pressure: 3 pushes with out_ready=0
    bus.out_ready = 1'b0;
    push_wait(32'hFFF00093, "bp_accept_a");
    chk("bp_ready_one", 64'(bus.in_ready), 64'd1);
    push_wait(32'h123450B7, "bp_accept_b");
    chk("bp_ready_two", 64'(bus.in_ready), 64'd0);
    chk("bp_head", 64'(bus.out_imm), 64'hFFFF_FFFF);
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h001000EF;
    repeat (2) begin
      @(posedge clk); #1;
      chk("bp_hold_imm", 64'(bus.out_imm), 64'hFFFF_FFFF);
      chk("bp_hold_fmt", 64'(bus.out_fmt), 64'(FMT_I));
      chk("bp_hold_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    push_wait(32'h001000EF, "bp_accept_c");
    repeat (3) @(posedge clk);
    #1;
    chk("bp_drained", 64'(bus.out_valid), 64'd0);

    // flush while TWO with in_valid=1
    bus.out_ready = 1'b0;
    push_wait(32'h123450B7, "fl_accept_a");
    push_wait(32'hFE20AC23, "fl_accept_b");
    bus.in_valid = 1'b1;
    bus.in_instr = 32'hFE000EE3;
    flush        = 1'b1;
    @(posedge clk); #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_two_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_two_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("flush_no_emit", 64'(bus.out_valid), 64'd0);

    // flush while ONE drops the same-cycle push
    bus.out_ready = 1'b0;
    push_wait(32'h123450B7, "fl1_accept");
    bus.in_valid = 1'b1;
    bus.in_instr = 32'hFE20AC23;
    flush        = 1'b1;
    @(posedge clk); #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_one_valid", 64'(bus.out_valid), 64'd0);

    // reset mid-stream in TWO
    push_wait(32'h123450B7, "rs_accept_a");
    push_wait(32'hFE20AC23, "rs_accept_b");
    chk("rs_state_two", 64'(dbg_state), 64'(ST_TWO));
    #1 rst_n = 1'b0;
    #1;
    chk("rs_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rs_out_imm", 64'(bus.out_imm), 64'd0);
    chk("rs_out_fmt", 64'(bus.out_fmt), 64'(FMT_NONE));
    @(posedge clk);
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h4030D093;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("rs_new_valid", 64'(bus.out_valid), 64'd1);
    chk("rs_new_imm", 64'(bus.out_imm), 64'd3);

    // randomized traffic
    for (int c = 0; c < 500; c++) begin
      flush         = ($urandom_range(0, 24) == 0);
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_instr  = rand_instr();
      bus.out_ready = ($urandom_range(0, 9) < 6);
      @(posedge clk); #1;
    end
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
    chk("drain_valid", 64'(bus.out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
